// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count and programmable almost flags.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_EN is defined.
module sync_fifo_param #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AF_LVL = 14,
    parameter int unsigned AE_LVL = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef FIFO_ERR_EN
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow,
`endif
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_q;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;

    // Flags decode the count register directly so they track it in the same cycle.
    assign w_full       = (r_count == CNT_W'(DEPTH));
    assign w_empty      = (r_count == CNT_W'(0));
    assign w_wr_en      = push & ~w_full;
    assign w_rd_en      = pop & ~w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_W'(AF_LVL));
    assign almost_empty = (r_count <= CNT_W'(AE_LVL));
    assign count        = r_count;
    assign q            = r_q;

    // Storage is intentionally not reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_q      <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_en) begin
                r_q      <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    logic r_overflow;
    logic r_underflow;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push & w_full) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (pop & w_empty) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=4, DEPTH=16, AF_LVL=14, AE_LVL=2).
// Error-flag checks are active when FIFO_ERR_EN is defined for the build.
module tb_sync_fifo_param;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic [3:0] d;
    logic [3:0] q;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
`ifdef FIFO_ERR_EN
    logic       err_clr;
    logic       overflow;
    logic       underflow;
`endif

    int n_checks;
    int n_errors;

    sync_fifo_param #(
        .DATA_W (4),
        .DEPTH  (16),
        .AF_LVL (14),
        .AE_LVL (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .d            (d),
        .q            (q),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected count plus the flags it implies for DEPTH=16, AF=14, AE=2.
    task automatic check_occ(input string tag, input int exp_cnt);
        check({tag, " count"}, 32'(count), 32'(exp_cnt));
        check({tag, " full"}, 32'(full), 32'(exp_cnt == 16));
        check({tag, " empty"}, 32'(empty), 32'(exp_cnt == 0));
        check({tag, " afull"}, 32'(almost_full), 32'(exp_cnt >= 14));
        check({tag, " aempty"}, 32'(almost_empty), 32'(exp_cnt <= 2));
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic cyc(input logic i_push, input logic i_pop, input logic [3:0] i_d);
        push = i_push;
        pop  = i_pop;
        d    = i_d;
        @(posedge clk);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        d     = 4'd0;
`ifdef FIFO_ERR_EN
        err_clr = 1'b0;
`endif

        // 1: reset
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst q", 32'(q), 32'd0);
        check_occ("rst", 0);
`ifdef FIFO_ERR_EN
        check("rst ovf", 32'(overflow), 32'd0);
        check("rst udf", 32'(underflow), 32'd0);
`endif

        // 2: fill with 1..15,0 then two dropped pushes
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 4'((i + 1) % 16));
            check_occ("fill", i + 1);
        end
        cyc(1'b1, 1'b0, 4'd2);
        cyc(1'b1, 1'b0, 4'd3);
        check_occ("ovf", 16);
`ifdef FIFO_ERR_EN
        check("ovf flag", 32'(overflow), 32'd1);
`endif

        // 3: drain in order, then an extra pop and error clear
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 4'd0);
            check("drain q", 32'(q), 32'((i + 1) % 16));
            check_occ("drain", 15 - i);
        end
        cyc(1'b0, 1'b1, 4'd0);
        check("udf q", 32'(q), 32'd0);
        check_occ("udf", 0);
`ifdef FIFO_ERR_EN
        check("udf flag", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 4'd0);
        err_clr = 1'b0;
        check("clr ovf", 32'(overflow), 32'd0);
        check("clr udf", 32'(underflow), 32'd0);
`endif

        // 4: count=5 then 8 cycles of simultaneous push+pop
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 4'(i));
        check_occ("pre-pp", 5);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 4'(6 + i));
            check("pp q", 32'(q), 32'(i + 1));
            check_occ("pp", 5);
        end
`ifdef FIFO_ERR_EN
        check("pp ovf", 32'(overflow), 32'd0);
        check("pp udf", 32'(underflow), 32'd0);
`endif

        // 5a: contents 9..13, fill with 14,15,0..8, then push(9)+pop at full
        for (int k = 0; k < 11; k++) cyc(1'b1, 1'b0, 4'((14 + k) % 16));
        check_occ("full2", 16);
        cyc(1'b1, 1'b1, 4'd9);
        check("fpp q", 32'(q), 32'd9);
        check_occ("fpp", 15);
`ifdef FIFO_ERR_EN
        check("fpp ovf", 32'(overflow), 32'd1);
`endif
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 1'b1, 4'd0);
            check("fpp drain q", 32'(q), 32'((10 + k) % 16));
        end
        check_occ("fpp drained", 0);

        // 5b: push(7)+pop while empty: push only, no read-through
        cyc(1'b1, 1'b1, 4'd7);
        check("epp q", 32'(q), 32'd8);
        check_occ("epp", 1);
        cyc(1'b0, 1'b1, 4'd0);
        check("epp pop q", 32'(q), 32'd7);
        check_occ("epp pop", 0);

        // 6: reset mid-operation, then no stale data
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 4'(k));
        check_occ("pre-rst", 10);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        check("mrst q", 32'(q), 32'd0);
        check_occ("mrst", 0);
`ifdef FIFO_ERR_EN
        check("mrst ovf", 32'(overflow), 32'd0);
        check("mrst udf", 32'(underflow), 32'd0);
`endif
        cyc(1'b1, 1'b0, 4'd3);
        check_occ("post push", 1);
        cyc(1'b0, 1'b1, 4'd0);
        check("post q", 32'(q), 32'd3);
        check_occ("post pop", 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
